// File: rtl/phase_countdown_if.sv
// Bundle of the sequencer's control inputs and display/lamp outputs.
// The controller side uses master; the phase_countdown core uses slave.
interface phase_countdown_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] dur_ns_go;
    logic [CNT_W-1:0] dur_ew_go;
    logic [CNT_W-1:0] dur_warn;
    logic             hold;
    logic             flash_mode;
    logic [CNT_W-1:0] count;
    logic [2:0]       phase;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             phase_done;

    modport master (
        output dur_ns_go, dur_ew_go, dur_warn, hold, flash_mode,
        input  count, phase, ns_light, ew_light, phase_done
    );

    modport slave (
        input  dur_ns_go, dur_ew_go, dur_warn, hold, flash_mode,
        output count, phase, ns_light, ew_light, phase_done
    );
endinterface

// File: rtl/phase_countdown.sv
// Two-approach intersection phase sequencer with a per-phase tick countdown,
// hold/freeze and a night flash mode. Lamp encoding is {R,Y,G}.
module phase_countdown #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 10
) (
    input  logic              clk,
    input  logic              rst,
    phase_countdown_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] PH_NS_GO   = 3'd0;
    localparam logic [2:0] PH_NS_WARN = 3'd1;
    localparam logic [2:0] PH_EW_GO   = 3'd2;
    localparam logic [2:0] PH_EW_WARN = 3'd3;
    localparam logic [2:0] PH_FLASH   = 3'd4;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_phase;
    logic [2:0]       r_ns;
    logic [2:0]       r_ew;
    logic             r_done;
    logic             r_toggle;

    logic             w_tick;
    logic [2:0]       w_next_phase;
    logic [CNT_W-1:0] w_next_load;

    // Initial count for a phase: a zero duration still lasts one tick.
    function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_ONE;
    endfunction

    function automatic logic [2:0] ns_lamp(input logic [2:0] ph);
        case (ph)
            PH_NS_GO:   return LAMP_G;
            PH_NS_WARN: return LAMP_Y;
            default:    return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input logic [2:0] ph);
        case (ph)
            PH_EW_GO:   return LAMP_G;
            PH_EW_WARN: return LAMP_Y;
            default:    return LAMP_R;
        endcase
    endfunction

    assign w_tick = (r_presc == PRESC_MAX);

    // Successor phase in the normal ring and its freshly sampled duration.
    always_comb begin
        w_next_phase = PH_NS_GO;
        w_next_load  = eff_m1(bus.dur_ns_go);
        case (r_phase)
            PH_NS_GO: begin
                w_next_phase = PH_NS_WARN;
                w_next_load  = eff_m1(bus.dur_warn);
            end
            PH_NS_WARN: begin
                w_next_phase = PH_EW_GO;
                w_next_load  = eff_m1(bus.dur_ew_go);
            end
            PH_EW_GO: begin
                w_next_phase = PH_EW_WARN;
                w_next_load  = eff_m1(bus.dur_warn);
            end
            default: begin
                w_next_phase = PH_NS_GO;
                w_next_load  = eff_m1(bus.dur_ns_go);
            end
        endcase
    end

    // Sequencer state: reset > flash > hold > normal countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_NS_GO;
            r_count  <= eff_m1(bus.dur_ns_go);
            r_presc  <= '0;
            r_done   <= 1'b0;
            r_ns     <= LAMP_G;
            r_ew     <= LAMP_R;
            r_toggle <= 1'b0;
        end else if (bus.flash_mode) begin
            r_done <= 1'b0;
            if (r_phase != PH_FLASH) begin
                r_phase  <= PH_FLASH;
                r_count  <= '0;
                r_presc  <= '0;
                r_toggle <= 1'b1;
                r_ns     <= LAMP_Y;
                r_ew     <= LAMP_Y;
            end else if (w_tick) begin
                // Hold is deliberately ignored here; the flash keeps blinking.
                r_presc  <= '0;
                r_toggle <= ~r_toggle;
                r_ns     <= {1'b0, ~r_toggle, 1'b0};
                r_ew     <= {1'b0, ~r_toggle, 1'b0};
            end else begin
                r_presc <= r_presc + PRESC_ONE;
            end
        end else if (r_phase == PH_FLASH) begin
            // Leaving night mode restarts the ring from a fresh NS green.
            r_phase <= PH_NS_GO;
            r_count <= eff_m1(bus.dur_ns_go);
            r_presc <= '0;
            r_done  <= 1'b0;
            r_ns    <= LAMP_G;
            r_ew    <= LAMP_R;
        end else if (bus.hold) begin
            // Everything but the one-cycle done pulse stays frozen.
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                r_presc <= '0;
                if (r_count != '0) begin
                    r_count <= r_count - CNT_ONE;
                end else begin
                    r_phase <= w_next_phase;
                    r_count <= w_next_load;
                    r_done  <= 1'b1;
                    r_ns    <= ns_lamp(w_next_phase);
                    r_ew    <= ew_lamp(w_next_phase);
                end
            end else begin
                r_presc <= r_presc + PRESC_ONE;
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.phase      = r_phase;
    assign bus.ns_light   = r_ns;
    assign bus.ew_light   = r_ew;
    assign bus.phase_done = r_done;
endmodule

// File: tb/tb_phase_countdown.sv
// Self-checking bench for phase_countdown: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_phase_countdown;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 10;

    logic clk;
    logic rst;

    phase_countdown_if #(.CNT_W(CNT_W)) ifc ();

    phase_countdown #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: which phase, ticks left shown, cycles into the tick.
    int m_phase = 0;
    int m_count = 0;
    int m_sub   = 0;
    bit m_tog   = 1'b0;
    bit m_done  = 1'b0;

    function automatic int ticks_of(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int dur_of(input int ph);
        case (ph)
            0:       return int'(ifc.dur_ns_go);
            2:       return int'(ifc.dur_ew_go);
            default: return int'(ifc.dur_warn);
        endcase
    endfunction

    function automatic int lamp_ns(input int ph, input bit tog);
        case (ph)
            0:       return 1;
            1:       return 2;
            4:       return tog ? 2 : 0;
            default: return 4;
        endcase
    endfunction

    function automatic int lamp_ew(input int ph, input bit tog);
        case (ph)
            2:       return 1;
            3:       return 2;
            4:       return tog ? 2 : 0;
            default: return 4;
        endcase
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_count = ticks_of(dur_of(0)) - 1; m_sub = 0; m_tog = 1'b0;
        end else if (ifc.flash_mode) begin
            if (m_phase != 4) begin
                m_phase = 4; m_count = 0; m_sub = 0; m_tog = 1'b1;
            end else begin
                m_sub = m_sub + 1;
                if (m_sub == TICK_DIV) begin m_sub = 0; m_tog = !m_tog; end
            end
        end else if (m_phase == 4) begin
            m_phase = 0; m_count = ticks_of(dur_of(0)) - 1; m_sub = 0;
        end else if (!ifc.hold) begin
            m_sub = m_sub + 1;
            if (m_sub == TICK_DIV) begin
                m_sub = 0;
                if (m_count > 0) m_count = m_count - 1;
                else begin
                    m_phase = (m_phase + 1) % 4;
                    m_count = ticks_of(dur_of(m_phase)) - 1;
                    m_done  = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the inputs seen at the edge, then compare.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("count", 32'(ifc.count), 32'(m_count));
        chk("phase", 32'(ifc.phase), 32'(m_phase));
        chk("ns_light", 32'(ifc.ns_light), 32'(lamp_ns(m_phase, m_tog)));
        chk("ew_light", 32'(ifc.ew_light), 32'(lamp_ew(m_phase, m_tog)));
        chk("phase_done", 32'(ifc.phase_done), 32'(m_done));
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (ifc.phase_done !== 1'b1 && n < bound);
        chk("done_timeout", 32'(ifc.phase_done), 32'd1);
    endtask

    int n;
    int pulses;
    int saved;

    initial begin
        rst = 1'b1;
        ifc.dur_ns_go  = 8'd30;
        ifc.dur_ew_go  = 8'd15;
        ifc.dur_warn   = 8'd3;
        ifc.hold       = 1'b0;
        ifc.flash_mode = 1'b0;
        #2;
        cyc();
        cyc();
        chk("rst_count", 32'(ifc.count), 32'd29);
        chk("rst_phase", 32'(ifc.phase), 32'd0);
        chk("rst_ns", 32'(ifc.ns_light), 32'b001);
        chk("rst_ew", 32'(ifc.ew_light), 32'b100);

        // Release reset and follow the first NS green.
        rst = 1'b0;
        repeat (10) cyc();
        chk("s1_count28", 32'(ifc.count), 32'd28);
        wait_done(400, n);
        chk("s1_len", 32'(n), 32'd290);
        chk("s1_phase", 32'(ifc.phase), 32'd1);
        chk("s1_count", 32'(ifc.count), 32'd2);

        // Rest of the full ring.
        pulses = 1;
        repeat (210) begin
            cyc();
            if (ifc.phase_done === 1'b1) pulses++;
        end
        chk("s2_pulses", 32'(pulses), 32'd4);
        chk("s2_phase", 32'(ifc.phase), 32'd0);
        chk("s2_count", 32'(ifc.count), 32'd29);

        // Hold for 25 clk in NS green; the phase end slips by 25 clk.
        repeat (50) cyc();
        saved = int'(ifc.count);
        ifc.hold = 1'b1;
        repeat (25) cyc();
        chk("s3_frozen", 32'(ifc.count), 32'(saved));
        ifc.hold = 1'b0;
        wait_done(400, n);
        chk("s3_len", 32'(n), 32'd250);

        // Short EW green and zero-length warn phases.
        ifc.dur_ew_go = 8'd5;
        wait_done(100, n);
        chk("s4_nswarn_len", 32'(n), 32'd30);
        chk("s4_ew_load", 32'(ifc.count), 32'd4);
        ifc.dur_warn = 8'd0;
        wait_done(100, n);
        chk("s4_ew_len", 32'(n), 32'd50);
        chk("s4_warn_count", 32'(ifc.count), 32'd0);
        wait_done(100, n);
        chk("s4_ewwarn_len", 32'(n), 32'd10);
        wait_done(400, n);
        chk("s4_nswarn0_cnt", 32'(ifc.count), 32'd0);
        wait_done(100, n);
        chk("s4_nswarn0_len", 32'(n), 32'd10);
        ifc.dur_warn  = 8'd3;
        ifc.dur_ew_go = 8'd15;

        // Night flash entered from EW green.
        repeat (7) cyc();
        ifc.flash_mode = 1'b1;
        cyc();
        chk("s5_phase", 32'(ifc.phase), 32'd4);
        chk("s5_ns_on", 32'(ifc.ns_light), 32'b010);
        chk("s5_ew_on", 32'(ifc.ew_light), 32'b010);
        ifc.hold = 1'b1;
        repeat (10) cyc();
        chk("s5_ns_off", 32'(ifc.ns_light), 32'b000);
        chk("s5_ew_off", 32'(ifc.ew_light), 32'b000);
        ifc.hold = 1'b0;
        repeat (10) cyc();
        chk("s5_ns_on2", 32'(ifc.ns_light), 32'b010);
        ifc.flash_mode = 1'b0;
        cyc();
        chk("s5_exit_phase", 32'(ifc.phase), 32'd0);
        chk("s5_exit_count", 32'(ifc.count), 32'd29);
        repeat (10) cyc();
        chk("s5_exit_dec", 32'(ifc.count), 32'd28);

        // Reset pulse during EW warn while held.
        n = 0;
        while (ifc.phase !== 3'd3 && n < 1000) begin cyc(); n++; end
        chk("s6_reach_ewwarn", 32'(ifc.phase), 32'd3);
        ifc.hold = 1'b1;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("s6_rst_count", 32'(ifc.count), 32'd29);
        chk("s6_rst_phase", 32'(ifc.phase), 32'd0);
        chk("s6_rst_ns", 32'(ifc.ns_light), 32'b001);
        chk("s6_rst_done", 32'(ifc.phase_done), 32'd0);
        rst = 1'b0;
        ifc.hold = 1'b0;
        repeat (10) cyc();
        chk("s6_count28", 32'(ifc.count), 32'd28);
        wait_done(400, n);
        chk("s6_len", 32'(n), 32'd290);

        // Randomized durations, hold, flash and reset against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ifc.dur_ns_go = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) ifc.dur_ew_go = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) ifc.dur_warn  = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  ifc.hold = ~ifc.hold;
            if ($urandom_range(0, 99) == 0) ifc.flash_mode = ~ifc.flash_mode;
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
